logic_op_pipe: RTL and testbench

//  Parametrised, registered bitwise logic unit. Successor to the fixed 4-bit AND/OR gate block.
//  Two WIDTH-bit operands are combined by a runtime-selected op (8 ops). The result, its AND/OR

---
 rtl/logic_op_pipe.sv | 99 +++++++++
 tb/tb_logic_op_pipe.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_pipe.sv
// Registered bitwise logic unit: eight runtime-selected ops on two WIDTH-bit operands,
// one output register with valid/ready handshake and a saturating completed-beat counter.
module logic_op_pipe #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             red_and,
   output logic             red_or,
   output logic [CNT_W-1:0] op_count,
   input  logic             clr_count
);

   function automatic logic [WIDTH-1:0] apply_op(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic [2:0]       sel);
      logic [WIDTH-1:0] r;
      case (sel)
         3'd0:    r = x & y;
         3'd1:    r = x | y;
         3'd2:    r = x ^ y;
         3'd3:    r = ~(x & y);
         3'd4:    r = ~(x | y);
         3'd5:    r = ~(x ^ y);
         3'd6:    r = x & ~y;
         default: r = x;
      endcase
      return r;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      if (c == {CNT_W{1'b1}}) return c;
      return c + 1'b1;
   endfunction

   logic             vld_q, vld_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             rand_q, rand_d;
   logic             ror_q, ror_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             in_acc, out_acc;

   // The register is the only state; out_valid doubles as the EMPTY/FULL flag.
   always_comb begin
      in_ready = !vld_q | out_ready;
      in_acc   = in_valid & in_ready;
      out_acc  = vld_q & out_ready;

      res_d  = res_q;
      rand_d = rand_q;
      ror_d  = ror_q;
      vld_d  = vld_q;
      cnt_d  = cnt_q;

      if (in_acc) begin
         res_d  = apply_op(a, b, op);
         rand_d = &res_d;
         ror_d  = |res_d;
         vld_d  = 1'b1;
      end else if (out_acc) begin
         vld_d  = 1'b0;
      end

      if (clr_count)    cnt_d = '0;
      else if (out_acc) cnt_d = sat_inc(cnt_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= 1'b0;
         res_q  <= '0;
         rand_q <= 1'b0;
         ror_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         vld_q  <= vld_d;
         res_q  <= res_d;
         rand_q <= rand_d;
         ror_q  <= ror_d;
         cnt_q  <= cnt_d;
      end
   end

   assign out_valid = vld_q;
   assign result    = res_q;
   assign red_and   = rand_q;
   assign red_or    = ror_q;
   assign op_count  = cnt_q;

endmodule

// File: tb/tb_logic_op_pipe.sv
// Scoreboard bench for logic_op_pipe: directed beats push hand-computed expectations,
// an output monitor pops and compares on every output handshake.
module tb_logic_op_pipe;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] a = '0, b = '0;
   logic [2:0] op = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [3:0] result;
   logic       red_and, red_or;
   logic [7:0] op_count;
   logic       clr_count = 1'b0;

   // second instance with a 2-bit counter for saturation
   logic       in2_valid = 1'b0, in2_ready, out2_valid, out2_ready = 1'b0;
   logic [3:0] a2 = 4'h5, b2 = 4'h3, result2;
   logic [2:0] op2 = 3'd0;
   logic       red2_and, red2_or, clr2 = 1'b0;
   logic [1:0] op2_count;

   int checks = 0;
   int errors = 0;

   logic [3:0] exp_r = '0;
   logic       exp_and = 1'b0, exp_or = 1'b0;
   logic [5:0] sb_q[$];

   always #5 clk = ~clk;

   logic_op_pipe #(.WIDTH(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .red_and(red_and), .red_or(red_or),
      .op_count(op_count), .clr_count(clr_count));

   logic_op_pipe #(.WIDTH(4), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in2_valid), .in_ready(in2_ready),
      .a(a2), .b(b2), .op(op2), .out_valid(out2_valid), .out_ready(out2_ready),
      .result(result2), .red_and(red2_and), .red_or(red2_or),
      .op_count(op2_count), .clr_count(clr2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // input side: record expectation on every accepted beat
   always @(negedge clk) begin
      if (rst_n && in_valid && in_ready)
         sb_q.push_back({exp_r, exp_and, exp_or});
   end

   // output side: compare on every output handshake
   always @(negedge clk) begin
      logic [5:0] e;
      if (rst_n && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_output", 32'(result), 32'hDEAD);
         end else begin
            e = sb_q.pop_front();
            chk("sb_result", 32'(result), 32'(e[5:2]));
            chk("sb_red_and", 32'(red_and), 32'(e[1]));
            chk("sb_red_or", 32'(red_or), 32'(e[0]));
         end
      end
   end

   task automatic send(input logic [3:0] ta, input logic [3:0] tb, input logic [2:0] top,
                       input logic [3:0] er, input logic ea, input logic eo,
                       output int tries);
      logic acc;
      a = ta; b = tb; op = top;
      exp_r = er; exp_and = ea; exp_or = eo;
      in_valid = 1'b1;
      tries = 0;
      acc = 1'b0;
      while (!acc) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         tries++;
         if (!acc && tries >= 20) begin
            chk("accept_timeout", 32'(tries), 32'd0);
            acc = 1'b1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] sweep_exp[8];
   logic [1:0] cnt_exp[5];

   initial begin
      int t;
      sweep_exp = '{4'h8, 4'hE, 4'h6, 4'h7, 4'h1, 4'h9, 4'h4, 4'hC};
      cnt_exp   = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

      // reset state
      #3;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_op_count", 32'(op_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // reset in the middle of a stall
      out_ready = 1'b0;
      send(4'hF, 4'h3, 3'd0, 4'h3, 1'b0, 1'b1, t);
      in_valid = 1'b0;
      tick();
      chk("stall_held_valid", 32'(out_valid), 32'd1);
      chk("stall_held_result", 32'(result), 32'h3);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_result", 32'(result), 32'd0);
      chk("async_rst_count", 32'(op_count), 32'd0);
      sb_q.delete();
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      tick();

      // op sweep, one beat at a time, 1-clock latency
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send(4'hC, 4'hA, 3'(i), sweep_exp[i], 1'b0, 1'b1, t);
         in_valid = 1'b0;
         chk("sweep_latency_valid", 32'(out_valid), 32'd1);
         tick();
         chk("sweep_drained", 32'(out_valid), 32'd0);
      end

      // back-to-back burst of 16
      clr_count = 1'b1;
      tick();
      clr_count = 1'b0;
      chk("clr_count", 32'(op_count), 32'd0);
      for (int i = 0; i < 16; i++) begin
         send(4'(i), 4'h0, 3'd7, 4'(i), (i == 15), (i != 0), t);
         chk("burst_single_try", 32'(t), 32'd1);
      end
      in_valid = 1'b0;
      tick();
      chk("burst_op_count", 32'(op_count), 32'd16);
      chk("burst_drained", 32'(out_valid), 32'd0);

      // stall with changing input
      out_ready = 1'b0;
      send(4'h1, 4'h0, 3'd7, 4'h1, 1'b0, 1'b1, t);
      for (int i = 0; i < 5; i++) begin
         a = 4'(i + 2);
         exp_r = 4'(i + 2);
         tick();
         chk("stall_result", 32'(result), 32'h1);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      send(4'h9, 4'h0, 3'd7, 4'h9, 1'b0, 1'b1, t);
      chk("stall_release_try", 32'(t), 32'd1);
      in_valid = 1'b0;
      tick();

      // reductions
      send(4'hF, 4'hF, 3'd0, 4'hF, 1'b1, 1'b1, t);
      send(4'hF, 4'hF, 3'd2, 4'h0, 1'b0, 1'b0, t);
      in_valid = 1'b0;
      tick();
      tick();
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

      // 2-bit saturating counter
      in2_valid = 1'b1;
      out2_ready = 1'b1;
      tick();
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("sat_count", 32'(op2_count), 32'(cnt_exp[k]));
         if (k == 3) in2_valid = 1'b0;
      end
      in2_valid = 1'b1;
      tick();
      in2_valid = 1'b0;
      clr2 = 1'b1;
      tick();
      clr2 = 1'b0;
      chk("clr_over_inc", 32'(op2_count), 32'd0);
      chk("clr_beat_consumed", 32'(out2_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
